// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional build macro used by the design: UART_TX_SCHED_FIXED_PRIO_EN.
package uart_tx_sched_pkg;

    localparam int SYS_CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2,
        DRAIN     = 2'd3
    } sched_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational arbiter: first set request at or after the pointer, wrapping.
// UART_TX_SCHED_FIXED_PRIO_EN pins the search start to 0 (lowest index wins).
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_cand;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_start      = '0;
`else
    assign w_start = i_ptr;
`endif

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(w_start) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one toggle-activated UART transmitter between NUM_REQ byte requesters.
// Build macro UART_TX_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state     | meaning
// IDLE      | arbitrating; a winner is granted on the next edge
// WAIT_DONE | byte handed to transmitter, waiting for its done pulse
// GAP       | GAP_CYCLES idle cycles after a completed byte
// DRAIN     | reset hit mid-byte; swallow the transmitter's done silently
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0,
    parameter int GAP_W      = 16
) (
    input  logic                         i_sys_clk,
    input  logic                         i_sys_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [8*NUM_REQ-1:0]         i_data,
    output logic [NUM_REQ-1:0]           o_ack,
    output logic [NUM_REQ-1:0]           o_done,
    output logic [idx_w(NUM_REQ)-1:0]    o_grant_id,
    output logic                         o_busy,
    output logic [7:0]                   o_tx_byte,
    output logic                         o_tx_activate,
    input  logic                         i_tx_done
);

    localparam int IDX_W = idx_w(NUM_REQ);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [IDX_W-1:0]   r_grant_id;
    logic [7:0]         r_tx_byte;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_busy;
    // Not reset: the transmitter has no reset, so the toggle phase must survive ours.
    logic               r_tx_activate = 1'b0;
    logic               r_in_flight   = 1'b0;

    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic [IDX_W-1:0]   w_ptr;
    logic               w_grant;
    logic               w_complete;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr;
    assign w_ptr = r_rr_ptr;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_rr_ptr <= '0;
        end else if (w_complete) begin
            r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
    end
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (w_ptr),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (i_tx_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_sys_rst) begin
            w_grant     = 1'b0;
            w_complete  = 1'b0;
            w_state_nxt = (r_in_flight && !i_tx_done) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        r_state <= w_state_nxt;
        r_busy  <= (w_state_nxt != IDLE);
    end

    always_ff @(posedge i_sys_clk) begin
        if (w_grant) begin
            r_in_flight   <= 1'b1;
            r_tx_activate <= ~r_tx_activate;
        end else if (i_tx_done && (i_sys_rst || r_state == WAIT_DONE || r_state == DRAIN)) begin
            r_in_flight <= 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_ack      <= '0;
            r_done     <= '0;
            r_grant_id <= '0;
            r_tx_byte  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            if (w_grant) begin
                r_ack[w_arb_idx] <= 1'b1;
                r_grant_id       <= w_arb_idx;
                r_tx_byte        <= i_data[{w_arb_idx, 3'b000} +: 8];
            end
            if (w_complete) begin
                r_done[r_grant_id] <= 1'b1;
            end
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

    assign o_ack         = r_ack;
    assign o_done        = r_done;
    assign o_grant_id    = r_grant_id;
    assign o_busy        = r_busy;
    assign o_tx_byte     = r_tx_byte;
    assign o_tx_activate = r_tx_activate;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Drives the transmitter's toggle-style activate input and byte bus, and consumes its one-cycle done pulse.
- Returns per-requester accept and completion pulses.
- Sits between lab-level byte sources (button/status/echo logic) and the single TX pin.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- GAP_CYCLES, 0: idle cycles inserted after each byte completes, before the next grant; 0 disables the gap.
- GAP_W, 16: width of the gap counter; GAP_CYCLES must be less than 2^GAP_W.

Ports:
- i_sys_clk  in  1  system clock, 50 MHz.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester byte request; level-sensitive.
- i_data  in  8*NUM_REQ  request bytes; requester k uses bits [8k+7:8k].
- o_ack  out  NUM_REQ  one-cycle pulse: byte of requester k accepted.
- o_done  out  NUM_REQ  one-cycle pulse: byte of requester k fully transmitted, stop bit included.
- o_grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- o_busy  out  1  high in any state other than IDLE.
- o_tx_byte  out  8  to transmitter byte input.
- o_tx_activate  out  1  to transmitter activate input; toggles once per byte.
- i_tx_done  in  1  from transmitter done output.

Behaviour:
- States: IDLE, WAIT_DONE, GAP, DRAIN. All outputs are registered.
- IDLE:
  - If any i_req bit is set, pick the winner g: first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - On that same edge: o_tx_byte <= i_data[g]; o_tx_activate <= ~o_tx_activate; o_ack[g] <= 1; o_grant_id <= g; in_flight <= 1; go to WAIT_DONE.
  - If no i_req bit is set, stay in IDLE.
- Request-to-ack latency is 1 cycle. Data is sampled on the ack edge.
- Requesters hold i_req and i_data stable until ack. Dropping i_req before ack withdraws the request with no side effects.
- A requester whose i_req stays high after ack issues a new request. It re-arbitrates after the current byte completes.
- WAIT_DONE:
  - On i_tx_done: o_done[o_grant_id] <= 1; in_flight <= 0; rr_ptr <= (o_grant_id + 1) mod NUM_REQ.
  - Then go to GAP if GAP_CYCLES > 0, otherwise IDLE.
  - i_req is ignored in this state.
- GAP: the counter runs from 0 to GAP_CYCLES-1, then goes to IDLE. The counter clears on entry.
- Back-to-back throughput with GAP_CYCLES=0:
  - Done seen at cycle t, IDLE at t+1, activate toggles at t+2.
  - The transmitter is back in its idle state by then, so no byte is lost.
- i_tx_done outside WAIT_DONE or DRAIN is ignored. i_tx_done is only high for one cycle per byte.
- Reset behaviour:
  - Reset values: o_ack=0, o_done=0, o_grant_id=0, o_tx_byte=0, rr_ptr=0, gap counter=0.
  - o_tx_activate and in_flight are not reset (initial value 0). The transmitter has no reset, so its toggle phase must stay matched.
  - Reset with in_flight=0: go to IDLE, o_busy=0.
  - Reset with in_flight=1: go to DRAIN, o_busy=1.
  - DRAIN waits for i_tx_done, then clears in_flight and goes to IDLE. No o_done pulse is issued for the drained byte.
  - Reset in the same cycle as i_tx_done: the done is consumed, in_flight <= 0, go to IDLE.
- Pulses on o_ack and o_done never overlap for the same requester in the same cycle.

Optional Feature:
- UART_TX_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins. rr_ptr is removed. Starvation of high indices is allowed.
- UART_TX_SCHED_FIXED_PRIO_EN undefined: round-robin as described above.

Decomposition:
- Package uart_tx_sched_pkg holds:
  - state encoding localparams IDLE, WAIT_DONE, GAP, DRAIN;
  - the 50_000_000 system clock constant;
  - the index-width function.
- One sub-module, rr_arbiter:
  - inputs: req vector, pointer;
  - output: winner index and a valid flag;
  - purely combinational.
- The fixed-priority macro switches rr_arbiter's search start to 0.

Test Plan:
1. Single byte: i_req=0001, i_data[7:0]=0x55 -> o_ack[0] one cycle later; o_tx_byte=0x55; activate toggles once. After the transmitter's done, o_done[0] is pulsed and o_busy drops.
2. All requesters held, bytes 0xA0..0xA3, rr_ptr=0 -> grant order 0,1,2,3,0 with one ack and one done per byte. With the FIXED_PRIO macro defined, the order is 0,0,0...
3. GAP_CYCLES=3 -> exactly 3 cycles in GAP between o_done and the next o_ack. With GAP_CYCLES=0 -> o_ack 1 cycle after done.
4. Withdraw: i_req[2] pulsed high for 0 cycles relative to arbitration (dropped before the IDLE edge) -> no ack and no toggle.
5. Reset asserted mid-byte in WAIT_DONE -> o_busy=1 (DRAIN); no o_done; the next request after the drained done transmits correctly with the activate phase intact.
6. Reset coincident with i_tx_done -> IDLE next cycle, in_flight=0, and the next byte's activate toggle is accepted by the transmitter.
